dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Single-port arbiter and sequencer for the pipelined MIPS data memory (D_Mem).
- Shares the memory between the CPU MEM stage and an external loader/debug port used for preloading operands and dumping results.
- Stalls the pipeline while the CPU loses arbitration or waits on read latency.
- Sits between the MEM stage and the data memory, which has a 1-cycle registered read.

Parameters:
- ADDR_W, 8, word-address width.
- DATA_W, 32, data width.
- MAX_WAIT, 4, consecutive denied cycles after which ext wins arbitration (1..15).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  MEM-stage access request (LW/SW)
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  DATA_W  store data
- cpu_stall  out  1  hold MEM stage and all earlier stages
- cpu_rdata  out  DATA_W  load data
- cpu_rvalid  out  1  cpu_rdata valid this cycle
- ext_req  in  1  external request
- ext_we  in  1  1=write, 0=read
- ext_addr  in  ADDR_W  word address
- ext_wdata  in  DATA_W  write data
- ext_gnt  out  1  request accepted this cycle
- ext_rdata  out  DATA_W  read data
- ext_rvalid  out  1  ext_rdata valid
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid cycle after mem_en with mem_we=0

Behaviour:
- States: IDLE, CPU_RD, EXT_RD. Reset -> IDLE; wait counter cleared; all registered outputs 0.
- While reset is high, cpu_stall=0, ext_gnt=0 and mem_en=0.

IDLE arbitration (each cycle):
- CPU wins by default.
- Ext wins if it is the only requester, or if wait_cnt==MAX_WAIT.
- Winner drives mem_en=1, mem_we, mem_addr and mem_wdata combinationally this cycle.
- Loser sees no memory activity.

CPU grant:
- Store: write completes in the grant cycle; cpu_stall=0; state stays IDLE.
- Load: cpu_stall=1; next state CPU_RD.

CPU_RD:
- cpu_rvalid=1, cpu_rdata=mem_rdata, cpu_stall=0, mem_en=0.
- Next state IDLE.
- The CPU must hold cpu_req/addr stable through this cycle; its request is consumed here, not re-arbitrated.

CPU not granted:
- cpu_stall=1 whenever cpu_req=1 in IDLE and ext wins.
- cpu_stall=1 in EXT_RD when cpu_req=1.

Ext grant:
- ext_gnt=1 for one cycle.
- Write: completes in the grant cycle.
- Read: next state EXT_RD, where ext_rvalid=1, ext_rdata=mem_rdata, mem_en=0, then IDLE.
- Ext must hold req/addr/data until ext_gnt. If ext_req is still high on a later IDLE cycle, it is a new request.

Wait counter:
- Increments in each IDLE cycle with ext_req=1 and ext not granted; saturates at MAX_WAIT.
- Clears on ext grant, or in any cycle with ext_req=0.

Timing:
- cpu_rdata/ext_rdata are don't-care when the matching rvalid=0; the bench must not check them.
- Read latency: grant to rvalid = 1 cycle.
- Write occupancy: 1 cycle.
- Max CPU load time without contention: 2 cycles (1 stall cycle).
- Reset mid-read: in-flight response discarded; rvalid=0 in the cycle after reset; state IDLE.

Optional Feature:
DMEM_ARB_LOCK_EN
- With macro: extra input port ext_lock (1 bit).
  - When ext_lock=1 at an ext grant, the arbiter enters locked mode: ext wins every IDLE cycle regardless of cpu_req, and cpu_stall=1 whenever cpu_req=1.
  - Lock releases in the first IDLE cycle where ext_lock=0; normal arbitration resumes that cycle.
  - Wait counter held at 0 while locked.
- Without macro: no ext_lock port; behaviour exactly as above.

Test Plan:
- Ext preload: ext write addr 8 data 4 with cpu_req=0 -> ext_gnt same cycle, mem_we=1, mem_addr=8; a following ext read of addr 8 -> ext_rvalid next cycle, ext_rdata=4.
- CPU load: cpu_req load addr 8 (mem holds 4) -> cpu_stall=1 in cycle 1; cycle 2 cpu_rvalid=1, cpu_rdata=4, cpu_stall=0.
- Contention: cpu_req and ext_req both high, CPU issuing back-to-back stores -> CPU granted 4 cycles, ext granted on 5th cycle (MAX_WAIT=4), cpu_stall=1 that cycle, counter back to 0.
- CPU store addr 3 data 24 while ext read addr 3 pending in EXT_RD -> cpu_stall=1 during EXT_RD; store issues next cycle; subsequent ext read of addr 3 returns 24.
- Reset asserted during CPU_RD -> cpu_rvalid=0 and cpu_stall=0 next cycle, state IDLE, no mem_en during reset.
- With DMEM_ARB_LOCK_EN: ext_lock=1 across 3 ext writes to addrs 0..2 with cpu_req=1 throughout -> cpu_stall=1 for all 3 cycles, CPU granted in the cycle after ext_lock drops.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Single-port arbiter and sequencer in front of the pipelined MIPS data memory.
// The memory is shared between the CPU MEM stage and an external loader/debug
// port, which preloads operands and dumps results. The memory has a 1-cycle
// registered read, so a read grant is always followed by one response cycle.
// While that response cycle is in progress no new access is issued.
//
// Optional feature macro: DMEM_ARB_LOCK_EN
//   When defined, an extra input ext_lock lets the external port hold the
//   memory for a burst of accesses. The CPU is stalled for the whole burst.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   cpu_req/we/addr/wdata   MEM-stage access request (LW/SW)
//   cpu_stall         hold the MEM stage and every earlier stage
//   cpu_rdata/rvalid  load response, one cycle after the load grant
//   ext_req/we/addr/wdata   external access request
//   ext_lock          (DMEM_ARB_LOCK_EN only) request exclusive ownership
//   ext_gnt           external request accepted this cycle
//   ext_rdata/rvalid  external read response, one cycle after the grant
//   mem_en/we/addr/wdata    memory access strobe and command
//   mem_rdata         memory read data, valid the cycle after a read strobe
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,

  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              ext_lock,
`endif
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // IDLE is the only state in which new accesses are arbitrated; the two
  // read states are the response cycles of the registered memory read.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    EXT_RD = 2'd2
  } state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       cpu_rvalid_q;
  logic       ext_rvalid_q;
  logic       cpu_win;
  logic       ext_win;
  logic       locked;
  logic       lock_active;

`ifdef DMEM_ARB_LOCK_EN
  logic locked_q;

  // A lock only takes effect while ext keeps ext_lock high; the first IDLE
  // cycle with ext_lock low falls straight back to normal arbitration.
  assign locked      = locked_q;
  assign lock_active = locked_q && ext_lock;
`else
  assign locked      = 1'b0;
  assign lock_active = 1'b0;
`endif

  // Arbitration. The CPU wins by default so the pipeline keeps flowing; ext
  // wins when the CPU is not asking, when it has been starved for MAX_WAIT
  // cycles, or while it holds the lock. Nothing is granted during reset or
  // while a read response is being returned.
  always_comb begin
    cpu_win = 1'b0;
    ext_win = 1'b0;
    if (!reset && state == IDLE) begin
      if (lock_active) begin
        ext_win = ext_req;
      end else if (ext_req && (!cpu_req || wait_cnt == MAX_WAIT_C)) begin
        ext_win = 1'b1;
      end else if (cpu_req) begin
        cpu_win = 1'b1;
      end
    end
  end

  // The winner's command goes straight to the memory in the grant cycle so
  // a write completes in one cycle and a read returns one cycle later.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_win) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ext_win) begin
      mem_en    = 1'b1;
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end
  end

  // The CPU is held whenever its request cannot finish this cycle: it lost
  // arbitration, it was granted a load (data arrives next cycle), or the
  // memory is busy returning ext read data. A granted store and the load
  // response cycle both release the pipeline.
  always_comb begin
    cpu_stall = 1'b0;
    if (!reset && cpu_req) begin
      case (state)
        IDLE:    cpu_stall = !(cpu_win && cpu_we);
        EXT_RD:  cpu_stall = 1'b1;
        default: cpu_stall = 1'b0;
      endcase
    end
  end

  assign ext_gnt    = ext_win;
  assign cpu_rvalid = cpu_rvalid_q;
  assign ext_rvalid = ext_rvalid_q;
  assign cpu_rdata  = mem_rdata;
  assign ext_rdata  = mem_rdata;

  // Sequencer. A read grant moves to the matching response state for one
  // cycle and raises that side's rvalid together with it; writes never leave
  // IDLE. Reset drops any response still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cpu_rvalid_q <= 1'b0;
      ext_rvalid_q <= 1'b0;
    end else begin
      cpu_rvalid_q <= 1'b0;
      ext_rvalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_win && !cpu_we) begin
            state        <= CPU_RD;
            cpu_rvalid_q <= 1'b1;
          end else if (ext_win && !ext_we) begin
            state        <= EXT_RD;
            ext_rvalid_q <= 1'b1;
          end
        end
        CPU_RD:  state <= IDLE;
        EXT_RD:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Starvation counter for ext. It only counts IDLE cycles in which ext asked
  // and lost, holds through response cycles, and restarts whenever ext is
  // served or withdraws. It stays at zero while ext owns the lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!ext_req || ext_win || locked) begin
      wait_cnt <= '0;
    end else if (state == IDLE && wait_cnt < MAX_WAIT_C) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

`ifdef DMEM_ARB_LOCK_EN
  // Lock ownership: taken when ext is granted with ext_lock high, dropped in
  // the first IDLE cycle that sees ext_lock low.
  always_ff @(posedge clk) begin
    if (reset) begin
      locked_q <= 1'b0;
    end else if (ext_win && ext_lock) begin
      locked_q <= 1'b1;
    end else if (state == IDLE && !ext_lock) begin
      locked_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Self-checking bench for dmem_arbiter. A behavioural data memory with a
// 1-cycle registered read sits on the mem_* side. A transaction-level
// reference model (a word array plus a queue of responses due) predicts every
// output cycle by cycle. Directed vectors from a table cover the preload,
// load, contention and read/store ordering cases; a hand-written sequence
// covers reset during a load; random traffic follows.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              ext_req, ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_rvalid;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
`ifdef DMEM_ARB_LOCK_EN
  logic              ext_lock = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_stall (cpu_stall),
    .cpu_rdata (cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
`ifdef DMEM_ARB_LOCK_EN
    .ext_lock  (ext_lock),
`endif
    .ext_gnt   (ext_gnt),
    .ext_rdata (ext_rdata),
    .ext_rvalid(ext_rvalid),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Data memory seen by the DUT: write in the strobe cycle, registered read.
  logic [DATA_W-1:0] dmem [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) dmem[mem_addr] <= mem_wdata;
      else        mem_rdata <= dmem[mem_addr];
    end
  end

  // Reference model: the architectural memory contents and the responses
  // owed to each side, in order.
  typedef struct {
    bit                is_cpu;
    logic [DATA_W-1:0] data;
  } resp_t;

  logic [DATA_W-1:0] refmem [256];
  resp_t             resp_q [$];
  int                starve = 0;

  typedef struct {
    logic              cr, cw;
    logic [ADDR_W-1:0] ca;
    logic [DATA_W-1:0] cd;
    logic              er, ew;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    logic              x_stall, x_gnt, x_en, x_we;
    logic [ADDR_W-1:0] x_addr;
    logic              x_crv;
    logic [DATA_W-1:0] x_crd;
    logic              x_erv;
    logic [DATA_W-1:0] x_erd;
  } vec_t;

  vec_t vq [$];

  // Comparison helper shared by every check in the bench.
  task automatic check_output(input string name, input logic [DATA_W-1:0] act,
                              input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and let outputs settle.
  task automatic apply_stimulus(input logic r, input logic cr, input logic cw,
                                input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] cd,
                                input logic er, input logic ew,
                                input logic [ADDR_W-1:0] ea, input logic [DATA_W-1:0] ed);
    @(negedge clk);
    reset     = r;
    cpu_req   = cr;
    cpu_we    = cw;
    cpu_addr  = ca;
    cpu_wdata = cd;
    ext_req   = er;
    ext_we    = ew;
    ext_addr  = ea;
    ext_wdata = ed;
    #1;
  endtask

  // Predict this cycle's outputs from the arbitration rules, compare, then
  // advance the model to the next cycle.
  task automatic model_check(input bit rst);
    resp_t r;
    bit    busy, crv, erv, ext_w, cpu_w, x_stall;
    logic [DATA_W-1:0] rd;
    if (rst) begin
      check_output("rst_stall", cpu_stall, 0);
      check_output("rst_gnt", ext_gnt, 0);
      check_output("rst_mem_en", mem_en, 0);
      resp_q.delete();
      starve = 0;
    end else begin
      busy = 0; crv = 0; erv = 0; rd = '0;
      if (resp_q.size() > 0) begin
        r    = resp_q.pop_front();
        busy = 1;
        crv  = r.is_cpu;
        erv  = !r.is_cpu;
        rd   = r.data;
      end
      ext_w   = !busy && ext_req && (!cpu_req || starve == MAX_WAIT);
      cpu_w   = !busy && cpu_req && !ext_w;
      x_stall = cpu_req && (busy ? !crv : !(cpu_w && cpu_we));

      check_output("cpu_stall", cpu_stall, x_stall);
      check_output("ext_gnt", ext_gnt, ext_w);
      check_output("mem_en", mem_en, cpu_w || ext_w);
      check_output("cpu_rvalid", cpu_rvalid, crv);
      check_output("ext_rvalid", ext_rvalid, erv);
      if (crv) check_output("cpu_rdata", cpu_rdata, rd);
      if (erv) check_output("ext_rdata", ext_rdata, rd);
      if (cpu_w) begin
        check_output("mem_we_cpu", mem_we, cpu_we);
        check_output("mem_addr_cpu", mem_addr, cpu_addr);
        if (cpu_we) begin
          check_output("mem_wdata_cpu", mem_wdata, cpu_wdata);
          refmem[cpu_addr] = cpu_wdata;
        end else begin
          resp_q.push_back('{is_cpu: 1'b1, data: refmem[cpu_addr]});
        end
      end
      if (ext_w) begin
        check_output("mem_we_ext", mem_we, ext_we);
        check_output("mem_addr_ext", mem_addr, ext_addr);
        if (ext_we) begin
          check_output("mem_wdata_ext", mem_wdata, ext_wdata);
          refmem[ext_addr] = ext_wdata;
        end else begin
          resp_q.push_back('{is_cpu: 1'b0, data: refmem[ext_addr]});
        end
      end
      if (!ext_req || ext_w) starve = 0;
      else if (!busy && starve < MAX_WAIT) starve++;
    end
  endtask

  function automatic vec_t mk(logic cr, logic cw, logic [ADDR_W-1:0] ca, logic [DATA_W-1:0] cd,
                              logic er, logic ew, logic [ADDR_W-1:0] ea, logic [DATA_W-1:0] ed,
                              logic xs, logic xg, logic xe, logic xw, logic [ADDR_W-1:0] xa,
                              logic xcv, logic [DATA_W-1:0] xcd, logic xev, logic [DATA_W-1:0] xed);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.er = er; v.ew = ew; v.ea = ea; v.ed = ed;
    v.x_stall = xs; v.x_gnt = xg; v.x_en = xe; v.x_we = xw; v.x_addr = xa;
    v.x_crv = xcv; v.x_crd = xcd; v.x_erv = xev; v.x_erd = xed;
    return v;
  endfunction

  // Main test sequence.
  initial begin
    bit cbusy, ebusy, rst;
    logic cw, ew;
    logic [ADDR_W-1:0] ca, ea;
    logic [DATA_W-1:0] cd, ed;

    for (int i = 0; i < 256; i++) begin
      dmem[i]   = '0;
      refmem[i] = '0;
    end

    // Directed cycles:      cpu req/we/addr/data   ext req/we/addr/data   stall gnt en we addr  crv crd  erv erd
    vq.push_back(mk(0,0, 0,  0,   0,0, 0,0,   0,0,0,0, 0,  0,0, 0,0));
    vq.push_back(mk(0,0, 0,  0,   1,1, 8,4,   0,1,1,1, 8,  0,0, 0,0));
    vq.push_back(mk(0,0, 0,  0,   1,0, 8,0,   0,1,1,0, 8,  0,0, 0,0));
    vq.push_back(mk(0,0, 0,  0,   0,0, 0,0,   0,0,0,0, 0,  0,0, 1,4));
    vq.push_back(mk(1,0, 8,  0,   0,0, 0,0,   1,0,1,0, 8,  0,0, 0,0));
    vq.push_back(mk(1,0, 8,  0,   0,0, 0,0,   0,0,0,0, 0,  1,4, 0,0));
    vq.push_back(mk(1,1, 10, 100, 1,0, 8,0,   0,0,1,1, 10, 0,0, 0,0));
    vq.push_back(mk(1,1, 11, 101, 1,0, 8,0,   0,0,1,1, 11, 0,0, 0,0));
    vq.push_back(mk(1,1, 12, 102, 1,0, 8,0,   0,0,1,1, 12, 0,0, 0,0));
    vq.push_back(mk(1,1, 13, 103, 1,0, 8,0,   0,0,1,1, 13, 0,0, 0,0));
    vq.push_back(mk(1,1, 14, 104, 1,0, 8,0,   1,1,1,0, 8,  0,0, 0,0));
    vq.push_back(mk(1,1, 14, 104, 0,0, 0,0,   1,0,0,0, 0,  0,0, 1,4));
    vq.push_back(mk(1,1, 14, 104, 0,0, 0,0,   0,0,1,1, 14, 0,0, 0,0));
    vq.push_back(mk(0,0, 0,  0,   1,0, 3,0,   0,1,1,0, 3,  0,0, 0,0));
    vq.push_back(mk(1,1, 3,  24,  0,0, 0,0,   1,0,0,0, 0,  0,0, 1,0));
    vq.push_back(mk(1,1, 3,  24,  0,0, 0,0,   0,0,1,1, 3,  0,0, 0,0));
    vq.push_back(mk(0,0, 0,  0,   1,0, 3,0,   0,1,1,0, 3,  0,0, 0,0));
    vq.push_back(mk(0,0, 0,  0,   0,0, 0,0,   0,0,0,0, 0,  0,0, 1,24));
    vq.push_back(mk(0,0, 0,  0,   1,0, 10,0,  0,1,1,0, 10, 0,0, 0,0));
    vq.push_back(mk(0,0, 0,  0,   0,0, 0,0,   0,0,0,0, 0,  0,0, 1,100));

    $display("[TB] reset");
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1, 1,0,8,0, 1,0,8,0);
      model_check(1);
    end

    $display("[TB] directed vectors");
    foreach (vq[i]) begin
      apply_stimulus(0, vq[i].cr, vq[i].cw, vq[i].ca, vq[i].cd,
                     vq[i].er, vq[i].ew, vq[i].ea, vq[i].ed);
      check_output($sformatf("v%0d_stall", i), cpu_stall, vq[i].x_stall);
      check_output($sformatf("v%0d_gnt", i), ext_gnt, vq[i].x_gnt);
      check_output($sformatf("v%0d_mem_en", i), mem_en, vq[i].x_en);
      if (vq[i].x_en) begin
        check_output($sformatf("v%0d_mem_we", i), mem_we, vq[i].x_we);
        check_output($sformatf("v%0d_mem_addr", i), mem_addr, vq[i].x_addr);
      end
      check_output($sformatf("v%0d_cpu_rvalid", i), cpu_rvalid, vq[i].x_crv);
      check_output($sformatf("v%0d_ext_rvalid", i), ext_rvalid, vq[i].x_erv);
      if (vq[i].x_crv) check_output($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vq[i].x_crd);
      if (vq[i].x_erv) check_output($sformatf("v%0d_ext_rdata", i), ext_rdata, vq[i].x_erd);
      model_check(0);
    end

    // Reset lands in the load response cycle; the response must be dropped.
    $display("[TB] reset during cpu load");
    apply_stimulus(0, 1,0,8,0, 0,0,0,0);
    check_output("rl_grant_stall", cpu_stall, 1);
    model_check(0);
    apply_stimulus(1, 1,0,8,0, 1,0,8,0);
    model_check(1);
    apply_stimulus(0, 0,0,0,0, 0,0,0,0);
    check_output("rl_after_rvalid", cpu_rvalid, 0);
    check_output("rl_after_stall", cpu_stall, 0);
    check_output("rl_after_mem_en", mem_en, 0);
    model_check(0);
    apply_stimulus(0, 1,0,8,0, 0,0,0,0);
    check_output("rl_reload_stall", cpu_stall, 1);
    model_check(0);
    apply_stimulus(0, 1,0,8,0, 0,0,0,0);
    check_output("rl_reload_rvalid", cpu_rvalid, 1);
    check_output("rl_reload_rdata", cpu_rdata, 4);
    model_check(0);

    // Random traffic from both sides, each honouring its hold rules.
    $display("[TB] random traffic");
    cbusy = 0; ebusy = 0;
    cw = 0; ca = '0; cd = '0; ew = 0; ea = '0; ed = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (!cbusy && $urandom_range(0, 2) != 0) begin
        cbusy = 1;
        cw    = 1'($urandom_range(0, 1));
        ca    = ADDR_W'($urandom_range(0, 15));
        cd    = $urandom;
      end
      if (!ebusy && $urandom_range(0, 1) != 0) begin
        ebusy = 1;
        ew    = 1'($urandom_range(0, 1));
        ea    = ADDR_W'($urandom_range(0, 15));
        ed    = $urandom;
      end
      apply_stimulus(rst, cbusy, cw, ca, cd, ebusy, ew, ea, ed);
      model_check(rst);
      if (rst) begin
        cbusy = 0;
        ebusy = 0;
      end else begin
        if (cbusy && !cpu_stall) cbusy = 0;
        if (ebusy && ext_gnt)    ebusy = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
